// File: rtl/digital_tube_ctrl_pkg.sv
// Shared constants for the 7-segment display controller: register map,
// CTRL field positions and the blank segment pattern.
package digital_tube_ctrl_pkg;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] RegData = 2'd0;
  localparam logic [1:0] RegExt  = 2'd1;
  localparam logic [1:0] RegCtrl = 2'd2;

  // CTRL layout: [0]=EN, [8:1]=DP mask digits 0-7, [9]=DP for tube2
  localparam int unsigned CtrlW      = 10;
  localparam int unsigned CtrlEnBit  = 0;
  localparam int unsigned CtrlDpLsb  = 1;
  localparam int unsigned CtrlDpMsb  = 8;
  localparam int unsigned CtrlDpExt  = 9;

  // All segments off (active-low), decimal point off
  localparam logic [7:0] SegBlank = 8'hFF;

  // Build a full 8-bit tube pattern from 7 segments and the dp mask bit
  function automatic logic [7:0] tube_pattern(input logic [6:0] seg, input logic dp);
    return {~dp, seg};
  endfunction

endpackage

// File: rtl/digital_tube_ctrl_hex_to_seg.sv
// Hex digit to active-low 7-segment pattern, {g,f,e,d,c,b,a}.
module hex_to_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Pure lookup, every code covered
  always_comb begin
    seg = 7'h7F;
    unique case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/digital_tube_ctrl.sv
// Memory-mapped 7-segment controller: holds DATA/EXT/CTRL, scans two 4-digit
// banks plus one extra digit, and returns registered readback.
module digital_tube_ctrl
  import digital_tube_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  digital_tube0,
  output logic [7:0]  digital_tube1,
  output logic [7:0]  digital_tube2,
  output logic [3:0]  digital_tube_sel0,
  output logic [3:0]  digital_tube_sel1,
  output logic        digital_tube_sel2
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SCAN_DIV - 1);

  logic [31:0]      data_q;
  logic [3:0]       ext_q;
  logic [CtrlW-1:0] ctrl_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;

  logic             en;
  logic [7:0]       dp_mask;
  logic [15:0]      data_hi;
  logic [3:0]       digit0, digit1;
  logic [6:0]       seg0, seg1, seg2;
  logic [31:0]      rdata_d;
  logic [7:0]       tube0_d, tube1_d, tube2_d;
  logic [3:0]       sel_d;
  logic             sel2_d;

  // Byte-lane bits are never decoded
  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  assign en      = ctrl_q[CtrlEnBit];
  assign dp_mask = ctrl_q[CtrlDpMsb:CtrlDpLsb];
  assign data_hi = data_q[31:16];
  assign digit0  = data_q[{idx_q, 2'b00} +: 4];
  assign digit1  = data_hi[{idx_q, 2'b00} +: 4];

  hex_to_seg u_seg0 (.hex(digit0), .seg(seg0));
  hex_to_seg u_seg1 (.hex(digit1), .seg(seg1));
  hex_to_seg u_seg2 (.hex(ext_q),  .seg(seg2));

  // Register file writes; reset wins over a same-cycle write
  always_ff @(posedge clk_in) begin
    if (reset) begin
      data_q <= '0;
      ext_q  <= '0;
      ctrl_q <= '0;
    end else if (we) begin
      case (addr[3:2])
        RegData: data_q <= wdata;
        RegExt:  ext_q  <= wdata[3:0];
        RegCtrl: ctrl_q <= wdata[CtrlW-1:0];
        default: ;
      endcase
    end
  end

  // Prescaler and digit index; both parked at 0 while disabled
  always_ff @(posedge clk_in) begin
    if (reset || !en) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next readback word and display outputs from current state
  always_comb begin
    rdata_d = '0;
    case (addr[3:2])
      RegData: rdata_d = data_q;
      RegExt:  rdata_d = {28'd0, ext_q};
      RegCtrl: rdata_d = {{(32 - CtrlW){1'b0}}, ctrl_q};
      default: rdata_d = '0;
    endcase

    tube0_d = SegBlank;
    tube1_d = SegBlank;
    tube2_d = SegBlank;
    sel_d   = 4'b0000;
    sel2_d  = 1'b0;
    if (en) begin
      tube0_d = tube_pattern(seg0, dp_mask[{1'b0, idx_q}]);
      tube1_d = tube_pattern(seg1, dp_mask[{1'b1, idx_q}]);
      tube2_d = tube_pattern(seg2, ctrl_q[CtrlDpExt]);
      sel_d   = 4'b0001 << idx_q;
      sel2_d  = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rdata             <= '0;
      digital_tube0     <= SegBlank;
      digital_tube1     <= SegBlank;
      digital_tube2     <= SegBlank;
      digital_tube_sel0 <= 4'b0000;
      digital_tube_sel1 <= 4'b0000;
      digital_tube_sel2 <= 1'b0;
    end else begin
      rdata             <= rdata_d;
      digital_tube0     <= tube0_d;
      digital_tube1     <= tube1_d;
      digital_tube2     <= tube2_d;
      digital_tube_sel0 <= sel_d;
      digital_tube_sel1 <= sel_d;
      digital_tube_sel2 <= sel2_d;
    end
  end

endmodule

// File: tb/tb_digital_tube_ctrl.sv
// Self-checking bench for digital_tube_ctrl with a time-based reference model.
module tb_digital_tube_ctrl;

  localparam int SCAN_DIV = 4;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
  logic [3:0]  digital_tube_sel0, digital_tube_sel1;
  logic        digital_tube_sel2;

  int tests = 0;
  int fails = 0;

  digital_tube_ctrl #(.SCAN_DIV(SCAN_DIV), .CNT_W(16)) dut (
    .clk_in(clk_in), .reset(reset), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata),
    .digital_tube0(digital_tube0), .digital_tube1(digital_tube1),
    .digital_tube2(digital_tube2), .digital_tube_sel0(digital_tube_sel0),
    .digital_tube_sel1(digital_tube_sel1), .digital_tube_sel2(digital_tube_sel2)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: regs plus count of consecutive enabled clocks; the digit
  // shown is simply elapsed enabled time divided into SCAN_DIV-long slots.
  logic [31:0] m_data = '0;
  logic [3:0]  m_ext = '0;
  logic [9:0]  m_ctrl = '0;
  int          m_en_cyc = 0;
  logic [31:0] e_rdata = '0;
  logic [7:0]  e_tube0 = 8'hFF, e_tube1 = 8'hFF, e_tube2 = 8'hFF;
  logic [3:0]  e_sel = '0;
  logic        e_sel2 = 1'b0;

  function automatic logic [7:0] seg_tab(input logic [3:0] d);
    logic [7:0] tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tab[d];
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] d, input logic dp);
    return dp ? (seg_tab(d) & 8'h7F) : seg_tab(d);
  endfunction

  function automatic int m_idx();
    return (m_en_cyc / SCAN_DIV) % 4;
  endfunction

  always @(posedge clk_in) begin
    if (reset) begin
      m_data <= '0; m_ext <= '0; m_ctrl <= '0; m_en_cyc <= 0;
      e_rdata <= '0; e_tube0 <= 8'hFF; e_tube1 <= 8'hFF; e_tube2 <= 8'hFF;
      e_sel <= '0; e_sel2 <= 1'b0;
    end else begin
      case (addr[3:2])
        2'd0: e_rdata <= m_data;
        2'd1: e_rdata <= {28'd0, m_ext};
        2'd2: e_rdata <= {22'd0, m_ctrl};
        default: e_rdata <= '0;
      endcase
      if (m_ctrl[0]) begin
        e_tube0 <= seg_of(m_data[4*m_idx() +: 4], m_ctrl[1+m_idx()]);
        e_tube1 <= seg_of(m_data[16+4*m_idx() +: 4], m_ctrl[5+m_idx()]);
        e_tube2 <= seg_of(m_ext, m_ctrl[9]);
        e_sel <= 4'(1 << m_idx());
        e_sel2 <= 1'b1;
        m_en_cyc <= (m_en_cyc + 1) % (4 * SCAN_DIV);
      end else begin
        e_tube0 <= 8'hFF; e_tube1 <= 8'hFF; e_tube2 <= 8'hFF;
        e_sel <= '0; e_sel2 <= 1'b0;
        m_en_cyc <= 0;
      end
      if (we) begin
        case (addr[3:2])
          2'd0: m_data <= wdata;
          2'd1: m_ext <= wdata[3:0];
          2'd2: m_ctrl <= wdata[9:0];
          default: ;
        endcase
      end
    end
  end

  // Apply inputs at a falling edge, let one rising edge pass, return at the next falling edge
  task automatic step(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d);
    reset = r; we = w; addr = a; wdata = d;
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    step(1, 1, 4'h0, 32'hDEADBEEF);
    step(1, 1, 4'h8, 32'h0000_0001);
    tests++;
    if ({rdata, digital_tube0, digital_tube1, digital_tube2} !== {32'd0, 24'hFFFFFF} ||
        {digital_tube_sel0, digital_tube_sel1, digital_tube_sel2} !== 9'd0) begin
      fails++;
      $display("FAIL reset_state: got rdata=%h tubes=%h/%h/%h sels=%b/%b/%b, want 0/FF/0",
               rdata, digital_tube0, digital_tube1, digital_tube2,
               digital_tube_sel0, digital_tube_sel1, digital_tube_sel2);
    end
    step(0, 0, 4'h0, 0);
    step(0, 0, 4'h8, 0);
    tests++;
    if (rdata !== 32'd0 || digital_tube_sel0 !== 4'd0) begin
      fails++;
      $display("FAIL reset_write_dropped: got rdata=%h sel0=%b, want 0/0000", rdata,
               digital_tube_sel0);
    end
  endtask

  task automatic test_scan();
    step(1, 0, 0, 0);
    step(0, 1, 4'h0, 32'h1234ABCD);
    step(0, 1, 4'h4, 32'h7);
    step(0, 1, 4'h8, 32'h1);
    step(0, 0, 0, 0);
    tests++;
    if ({digital_tube_sel0, digital_tube_sel1, digital_tube0, digital_tube1, digital_tube2,
         digital_tube_sel2} !== {4'b0001, 4'b0001, 8'hA1, 8'h99, 8'hF8, 1'b1}) begin
      fails++;
      $display("FAIL scan_idx0: got sel=%b/%b tubes=%h/%h/%h sel2=%b, want 0001 A1/99/F8 1",
               digital_tube_sel0, digital_tube_sel1, digital_tube0, digital_tube1,
               digital_tube2, digital_tube_sel2);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    tests++;
    if ({digital_tube_sel0, digital_tube0, digital_tube1} !== {4'b0010, 8'hC6, 8'hB0}) begin
      fails++;
      $display("FAIL scan_idx1: got sel0=%b tubes=%h/%h, want 0010 C6/B0",
               digital_tube_sel0, digital_tube0, digital_tube1);
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0);
      tests++;
      if ({digital_tube0, digital_tube1, digital_tube2, digital_tube_sel0, digital_tube_sel1}
          !== {e_tube0, e_tube1, e_tube2, e_sel, e_sel}) begin
        fails++;
        $display("FAIL scan_model: got %h/%h/%h %b/%b, want %h/%h/%h %b", digital_tube0,
                 digital_tube1, digital_tube2, digital_tube_sel0, digital_tube_sel1,
                 e_tube0, e_tube1, e_tube2, e_sel);
      end
    end
    tests++;
    if ({digital_tube_sel0, digital_tube0} !== {4'b0001, 8'hA1}) begin
      fails++;
      $display("FAIL scan_full_cycle: got sel0=%b tube0=%h, want 0001 A1",
               digital_tube_sel0, digital_tube0);
    end
  endtask

  task automatic test_dp();
    step(0, 1, 4'h8, 32'h003);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      step(0, 0, 0, 0);
      tests++;
      if (digital_tube0[7] !== ((e_sel == 4'b0001) ? 1'b0 : 1'b1) || digital_tube1[7] !== 1'b1
          || digital_tube0 !== e_tube0) begin
        fails++;
        $display("FAIL dp_digit0: got tube0=%h tube1=%h sel0=%b, want tube0=%h dp1 off",
                 digital_tube0, digital_tube1, digital_tube_sel0, e_tube0);
      end
    end
  endtask

  task automatic test_wrap_write();
    bit found = 0;
    for (int i = 0; i < 4 * SCAN_DIV && !found; i++) begin
      if (m_ctrl[0] && (m_en_cyc % SCAN_DIV) == SCAN_DIV - 1) found = 1;
      else step(0, 0, 0, 0);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL wrap_search: got no wrap cycle, want one within %0d clocks", 4 * SCAN_DIV);
    end else begin
      step(0, 1, 4'h0, 32'hFFFFFFFF);
      step(0, 0, 0, 0);
      tests++;
      if ({digital_tube0[6:0], digital_tube1[6:0], digital_tube_sel0} !==
          {7'h0E, 7'h0E, e_sel} || digital_tube0 !== e_tube0) begin
        fails++;
        $display("FAIL wrap_write: got tubes=%h/%h sel0=%b, want 8E/8E sel0=%b",
                 digital_tube0, digital_tube1, digital_tube_sel0, e_sel);
      end
    end
  endtask

  task automatic test_readback();
    logic [3:0]  a   [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
    logic [31:0] exp [4] = '{32'h1234ABCD, 32'h7, 32'h003, 32'h0};
    step(1, 0, 0, 0);
    step(0, 1, 4'h0, 32'h1234ABCD);
    step(0, 1, 4'h4, 32'hFFFF_FFF7);
    step(0, 1, 4'h8, 32'hFFFF_F003);
    step(0, 1, 4'hC, 32'h5555_5555);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, a[i], 0);
      tests++;
      if (rdata !== exp[i]) begin
        fails++;
        $display("FAIL readback_%0h: got %h, want %h", a[i], rdata, exp[i]);
      end
    end
  endtask

  task automatic test_en_toggle();
    bit found = 0;
    for (int i = 0; i < 8 * SCAN_DIV && !found; i++) begin
      if (m_ctrl[0] && m_idx() == 2 && (m_en_cyc % SCAN_DIV) == 1) found = 1;
      else step(0, 0, 0, 0);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL en_search: got idx2 never reached, want within %0d clocks", 8 * SCAN_DIV);
    end else begin
      step(0, 1, 4'h8, 32'h0);
      step(0, 0, 0, 0);
      tests++;
      if ({digital_tube0, digital_tube1, digital_tube2} !== 24'hFFFFFF ||
          {digital_tube_sel0, digital_tube_sel1, digital_tube_sel2} !== 9'd0) begin
        fails++;
        $display("FAIL en_off_blank: got %h/%h/%h sels %b/%b/%b, want FF and 0",
                 digital_tube0, digital_tube1, digital_tube2,
                 digital_tube_sel0, digital_tube_sel1, digital_tube_sel2);
      end
      step(0, 1, 4'h8, 32'h1);
      step(0, 0, 0, 0);
      tests++;
      if ({digital_tube_sel0, digital_tube_sel1, digital_tube_sel2} !== {8'h11, 1'b1}) begin
        fails++;
        $display("FAIL en_restart_idx0: got sels %b/%b/%b, want 0001/0001/1",
                 digital_tube_sel0, digital_tube_sel1, digital_tube_sel2);
      end
    end
  endtask

  task automatic test_random();
    logic        r, w;
    logic [3:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      w = ($urandom_range(0, 2) == 0);
      a = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      d = $urandom;
      if (a[3:2] == 2'd2) d[0] = ($urandom_range(0, 5) != 0);
      step(r, w, a, d);
      tests++;
      if ({rdata, digital_tube0, digital_tube1, digital_tube2, digital_tube_sel0,
           digital_tube_sel1, digital_tube_sel2} !==
          {e_rdata, e_tube0, e_tube1, e_tube2, e_sel, e_sel, e_sel2}) begin
        fails++;
        $display("FAIL random_%0d: got rd=%h t=%h/%h/%h s=%b/%b/%b, want rd=%h t=%h/%h/%h s=%b/%b",
                 i, rdata, digital_tube0, digital_tube1, digital_tube2, digital_tube_sel0,
                 digital_tube_sel1, digital_tube_sel2, e_rdata, e_tube0, e_tube1, e_tube2,
                 e_sel, e_sel2);
      end
    end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_scan();
    test_dp();
    test_wrap_write();
    test_readback();
    step(0, 1, 4'h8, 32'h1);
    test_en_toggle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
